// File: rtl/axi4_burst_master_if.sv
// rtl/axi4_burst_master_if.sv - AXI4 (AXI3-style signal set) bus bundle between burst master and slave
//
// Purpose: groups the five AXI channels (AW, W, B, AR, R) into one bundle.
// Parameters: ID_W (ID width), ADDR_W (address width), DATA_W (data width);
//             the strobe width is DATA_W/8.
// Modports:
//   master - drives AW*/W*/AR* payload and valids, BREADY, RREADY;
//            samples AWREADY, WREADY, B*, ARREADY, R*.
//   slave  - the mirror image of master.

interface axi4_burst_master_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    // Write-address channel
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [3:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic [1:0]        AWLOCK;
    logic [3:0]        AWCACHE;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;

    // Write-data channel
    logic [ID_W-1:0]   WID;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;

    // Write-response channel
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    // Read-address channel
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [1:0]        ARLOCK;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;

    // Read-data channel
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - AXI4 INCR burst master driven by a command port and data streams
//
// Purpose: turns one command (write/read, address, length, id) into a single
// INCR burst of 1..16 beats. Write and read paths are independent FSMs, so one
// write and one read can be in flight at once.
//
// Optional feature macro: AXI4_BURST_MASTER_LEN_CHECK_EN
//   defined   - read beats are counted; rd_err latches (sticky until ARESET) when
//               RLAST disagrees with ARLEN.
//   undefined - rd_err is tied to 0 and no read beat counter exists.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_write selects write(1)/read(0)
//   cmd_addr/len/id       burst start address, beats-1, transaction id
//   wd_valid/wd_ready     write-data stream handshake, wd_data/wd_strb payload
//   rd_valid/rd_ready     read-data stream handshake, rd_data/rd_resp/rd_last payload
//   wr_done/wr_resp/wr_id one-cycle completion pulse with captured BRESP/BID
//   rd_err                sticky read length error (optional feature)
//   axi                   AXI bus, master side

module axi4_burst_master #(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SIZE_ENC = 3
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [ID_W-1:0]     cmd_id,

    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,

    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_last,

    output logic                wr_done,
    output logic [1:0]          wr_resp,
    output logic [ID_W-1:0]     wr_id,
    output logic                rd_err,

    axi4_burst_master_if.master axi
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    // ------------------------------------------------------------------
    // State and registered payload
    // ------------------------------------------------------------------
    wstate_t             wstate_q, wstate_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [3:0]          awlen_q,  awlen_d;
    logic [ID_W-1:0]     awid_q,   awid_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic                wr_done_q, wr_done_d;
    logic [1:0]          wr_resp_q, wr_resp_d;
    logic [ID_W-1:0]     wr_id_q,   wr_id_d;

    rstate_t             rstate_q, rstate_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [3:0]          arlen_q,  arlen_d;
    logic [ID_W-1:0]     arid_q,   arid_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic wr_accept;
    logic rd_accept;
    logic w_hs;
    logic r_hs;
    logic wlast;

    // cmd_ready looks at the idle state of whichever path the command targets,
    // so a read can be accepted while a write is busy and vice versa.
    assign cmd_ready = cmd_write ? (wstate_q == W_IDLE) : (rstate_q == R_IDLE);
    assign wr_accept = cmd_valid && cmd_ready && cmd_write;
    assign rd_accept = cmd_valid && cmd_ready && !cmd_write;

    // W beats are only offered after the AW handshake (state W_DATA).
    assign wd_ready  = (wstate_q == W_DATA) && axi.WREADY;
    assign w_hs      = (wstate_q == W_DATA) && wd_valid && axi.WREADY;
    assign wlast     = (wstate_q == W_DATA) && (beat_cnt_q == awlen_q);

    assign rd_valid  = (rstate_q == R_DATA) && axi.RVALID;
    assign r_hs      = (rstate_q == R_DATA) && axi.RVALID && rd_ready;

    // ------------------------------------------------------------------
    // Write-channel outputs
    // ------------------------------------------------------------------
    assign axi.AWID    = awid_q;
    assign axi.AWADDR  = awaddr_q;
    assign axi.AWLEN   = awlen_q;
    assign axi.AWSIZE  = 3'(SIZE_ENC);
    assign axi.AWBURST = 2'b01;
    assign axi.AWLOCK  = 2'b00;
    assign axi.AWCACHE = 4'b0000;
    assign axi.AWPROT  = 3'b000;
    assign axi.AWVALID = (wstate_q == W_ADDR);

    assign axi.WID     = awid_q;
    assign axi.WDATA   = wd_data;
    assign axi.WSTRB   = wd_strb;
    assign axi.WLAST   = wlast;
    assign axi.WVALID  = (wstate_q == W_DATA) && wd_valid;

    assign axi.BREADY  = (wstate_q == W_RESP);

    assign wr_done     = wr_done_q;
    assign wr_resp     = wr_resp_q;
    assign wr_id       = wr_id_q;

    // ------------------------------------------------------------------
    // Read-channel outputs
    // ------------------------------------------------------------------
    assign axi.ARID    = arid_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = arlen_q;
    assign axi.ARSIZE  = 3'(SIZE_ENC);
    assign axi.ARBURST = 2'b01;
    assign axi.ARLOCK  = 2'b00;
    assign axi.ARCACHE = 4'b0000;
    assign axi.ARPROT  = 3'b000;
    assign axi.ARVALID = (rstate_q == R_ADDR);

    assign axi.RREADY  = (rstate_q == R_DATA) && rd_ready;

    assign rd_data     = axi.RDATA;
    assign rd_resp     = axi.RRESP;
    assign rd_last     = axi.RLAST;

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        wstate_d   = wstate_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awid_d     = awid_q;
        beat_cnt_d = beat_cnt_q;
        wr_done_d  = 1'b0;
        wr_resp_d  = wr_resp_q;
        wr_id_d    = wr_id_q;

        case (wstate_q)
            W_IDLE: begin
                if (wr_accept) begin
                    awaddr_d = cmd_addr;
                    awlen_d  = cmd_len;
                    awid_d   = cmd_id;
                    wstate_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (axi.AWREADY) begin
                    beat_cnt_d = 4'd0;
                    wstate_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // The final beat leaves the counter at AWLEN, so it never wraps.
                    if (wlast) begin
                        wstate_d = W_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (axi.BVALID) begin
                    wr_done_d = 1'b1;
                    wr_resp_d = axi.BRESP;
                    wr_id_d   = axi.BID;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q   <= W_IDLE;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awid_q     <= '0;
            beat_cnt_q <= '0;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= '0;
            wr_id_q    <= '0;
        end else begin
            wstate_q   <= wstate_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awid_q     <= awid_d;
            beat_cnt_q <= beat_cnt_d;
            wr_done_q  <= wr_done_d;
            wr_resp_q  <= wr_resp_d;
            wr_id_q    <= wr_id_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
`ifdef AXI4_BURST_MASTER_LEN_CHECK_EN
    logic [3:0] rbeat_cnt_q, rbeat_cnt_d;
    logic       rd_err_q,    rd_err_d;

    assign rd_err = rd_err_q;

    always_comb begin
        rstate_d    = rstate_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arid_d      = arid_q;
        rbeat_cnt_d = rbeat_cnt_q;
        rd_err_d    = rd_err_q;

        case (rstate_q)
            R_IDLE: begin
                if (rd_accept) begin
                    araddr_d = cmd_addr;
                    arlen_d  = cmd_len;
                    arid_d   = cmd_id;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi.ARREADY) begin
                    rbeat_cnt_d = 4'd0;
                    rstate_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (axi.RLAST) begin
                        if (rbeat_cnt_q != arlen_q) begin
                            rd_err_d = 1'b1;
                        end
                        rstate_d = R_IDLE;
                    end else if (rbeat_cnt_q == arlen_q) begin
                        // Expected last beat came without RLAST: flag it and keep
                        // draining until the slave finally ends the burst. The
                        // counter parks at ARLEN instead of wrapping.
                        rd_err_d = 1'b1;
                    end else begin
                        rbeat_cnt_d = rbeat_cnt_q + 4'd1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rbeat_cnt_q <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            rbeat_cnt_q <= rbeat_cnt_d;
            rd_err_q    <= rd_err_d;
        end
    end
`else
    assign rd_err = 1'b0;

    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arid_d   = arid_q;

        case (rstate_q)
            R_IDLE: begin
                if (rd_accept) begin
                    araddr_d = cmd_addr;
                    arlen_d  = cmd_len;
                    arid_d   = cmd_id;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi.ARREADY) begin
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs && axi.RLAST) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            arid_q   <= '0;
        end else begin
            rstate_q <= rstate_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            arid_q   <= arid_d;
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - directed self-checking bench for axi4_burst_master

module tb_axi4_burst_master;

    logic        clk;
    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        wd_valid;
    logic        wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last;
    logic        wr_done;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_id;
    logic        rd_err;

    axi4_burst_master_if bus ();

    axi4_burst_master dut (
        .ACLK      (clk),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_id    (cmd_id),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_resp   (rd_resp),
        .rd_last   (rd_last),
        .wr_done   (wr_done),
        .wr_resp   (wr_resp),
        .wr_id     (wr_id),
        .rd_err    (rd_err),
        .axi       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

`ifdef AXI4_BURST_MASTER_LEN_CHECK_EN
    localparam logic EXP_LEN_ERR = 1'b1;
`else
    localparam logic EXP_LEN_ERR = 1'b0;
`endif

    // Scratch state for the directed steps
    int   hs, bad_last, bad_data, bad_rr, beat, held;
    logic done, stalled;
    int   c_wbeats, c_rbeats, c_rbad;
    logic c_wdone, c_rlast;
    logic [3:0] c_wid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ARESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_id    = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        wd_strb   = '0;
        rd_ready  = 1'b0;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BID     = '0;
        bus.BRESP   = '0;
        bus.BVALID  = 1'b0;
        bus.ARREADY = 1'b0;
        bus.RID     = '0;
        bus.RDATA   = '0;
        bus.RRESP   = '0;
        bus.RLAST   = 1'b0;
        bus.RVALID  = 1'b0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        chk("rst_awvalid", bus.AWVALID, 0);
        chk("rst_wvalid",  bus.WVALID, 0);
        chk("rst_bready",  bus.BREADY, 0);
        chk("rst_arvalid", bus.ARVALID, 0);
        chk("rst_rready",  bus.RREADY, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_wr_resp", wr_resp, 0);
        chk("rst_wr_id",   wr_id, 0);
        chk("rst_rd_err",  rd_err, 0);
        chk("rst_awaddr",  bus.AWADDR, 0);
        chk("rst_araddr",  bus.ARADDR, 0);
        ARESET = 1'b0;

        // ---------------- Single write ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000; cmd_len = 4'd0; cmd_id = 4'd3;
        #1;
        chk("w1_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        wd_valid = 1'b1; wd_data = 64'hA5A5_0000_0000_5A5A; wd_strb = 8'hFF;
        #1;
        chk("w1_awvalid", bus.AWVALID, 1);
        chk("w1_awaddr",  bus.AWADDR, 32'h1000);
        chk("w1_awlen",   bus.AWLEN, 0);
        chk("w1_awid",    bus.AWID, 3);
        chk("w1_awsize",  bus.AWSIZE, 3);
        chk("w1_awburst", bus.AWBURST, 1);
        chk("w1_w_before_aw", bus.WVALID, 0);
        chk("w1_cmd_ready_busy", cmd_ready, 0);
        bus.AWREADY = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b1;
        #1;
        chk("w1_awvalid_clr", bus.AWVALID, 0);
        chk("w1_wvalid", bus.WVALID, 1);
        chk("w1_wlast",  bus.WLAST, 1);
        chk("w1_wid",    bus.WID, 3);
        chk("w1_wdata",  bus.WDATA, 64'hA5A5_0000_0000_5A5A);
        chk("w1_wstrb",  bus.WSTRB, 8'hFF);
        chk("w1_wd_ready", wd_ready, 1);
        tick();
        bus.WREADY = 1'b0; wd_valid = 1'b0;
        bus.BVALID = 1'b1; bus.BRESP = 2'b00; bus.BID = 4'd3;
        #1;
        chk("w1_bready", bus.BREADY, 1);
        chk("w1_wvalid_after", bus.WVALID, 0);
        tick();
        bus.BVALID = 1'b0;
        chk("w1_wr_done", wr_done, 1);
        chk("w1_wr_resp", wr_resp, 0);
        chk("w1_wr_id",   wr_id, 3);
        chk("w1_bready_clr", bus.BREADY, 0);
        tick();
        chk("w1_wr_done_pulse", wr_done, 0);

        // ---------------- 16-beat write, AW stall, WREADY toggling ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000; cmd_len = 4'd15; cmd_id = 4'd5;
        tick();
        cmd_valid = 1'b0;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.AWVALID && bus.AWADDR == 32'h3000 && bus.AWLEN == 4'd15) held++;
            tick();
        end
        chk("w16_aw_held_5", held, 5);
        bus.AWREADY = 1'b1;
        #1;
        chk("w16_awvalid_at_hs", bus.AWVALID, 1);
        tick();
        bus.AWREADY = 1'b0;
        hs = 0; bad_last = 0; bad_data = 0; done = 1'b0;
        wd_valid = 1'b1; wd_strb = 8'hFF; wd_data = 64'd0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            bus.WREADY = cyc[0];
            #1;
            if (bus.WVALID && bus.WREADY) begin
                if (bus.WLAST !== (hs == 15)) bad_last++;
                if (bus.WDATA !== 64'(hs)) bad_data++;
                hs++;
                if (bus.WLAST) done = 1'b1;
            end
            tick();
            wd_data = 64'(hs);
        end
        bus.WREADY = 1'b0; wd_valid = 1'b0;
        chk("w16_finished", done, 1);
        chk("w16_hs_count", hs, 16);
        chk("w16_wlast_pos", bad_last, 0);
        chk("w16_wdata_order", bad_data, 0);
        bus.BVALID = 1'b1; bus.BRESP = 2'b10; bus.BID = 4'd5;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            done = wr_done;
        end
        bus.BVALID = 1'b0;
        chk("w16_wr_done", done, 1);
        chk("w16_wr_resp_slverr", wr_resp, 2);
        chk("w16_wr_id", wr_id, 5);

        // ---------------- 4-beat read with rd_ready stall on beat 2 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2000; cmd_len = 4'd3; cmd_id = 4'd7;
        #1;
        chk("r4_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("r4_arvalid", bus.ARVALID, 1);
        chk("r4_araddr",  bus.ARADDR, 32'h2000);
        chk("r4_arlen",   bus.ARLEN, 3);
        chk("r4_arid",    bus.ARID, 7);
        chk("r4_cmd_ready_busy", cmd_ready, 0);
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        chk("r4_arvalid_clr", bus.ARVALID, 0);
        beat = 0; bad_data = 0; bad_last = 0; bad_rr = 0; stalled = 1'b0; done = 1'b0;
        bus.RVALID = 1'b1; bus.RID = 4'd7; bus.RRESP = 2'b00;
        for (int cyc = 0; cyc < 32 && !done; cyc++) begin
            rd_ready   = !(beat == 2 && !stalled);
            bus.RDATA  = 64'hD0 + 64'(beat);
            bus.RLAST  = (beat == 3);
            #1;
            if (bus.RREADY !== rd_ready) bad_rr++;
            if (rd_valid && rd_ready) begin
                if (rd_data !== 64'hD0 + 64'(beat)) bad_data++;
                if (rd_last !== (beat == 3)) bad_last++;
                if (rd_last) done = 1'b1;
                beat++;
            end else if (beat == 2) begin
                stalled = 1'b1;
            end
            tick();
        end
        bus.RVALID = 1'b0; bus.RLAST = 1'b0; rd_ready = 1'b0;
        chk("r4_beats", beat, 4);
        chk("r4_stall_seen", stalled, 1);
        chk("r4_rready_follows", bad_rr, 0);
        chk("r4_rdata_order", bad_data, 0);
        chk("r4_rd_last_pos", bad_last, 0);
        chk("r4_cmd_ready_next", cmd_ready, 1);
        chk("r4_rd_err", rd_err, 0);

        // ---------------- Concurrent write len 3 and read len 3 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000; cmd_len = 4'd3; cmd_id = 4'd1;
        tick();
        cmd_write = 1'b0; cmd_addr = 32'h5000; cmd_len = 4'd3; cmd_id = 4'd2;
        #1;
        chk("cc_rd_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        c_wbeats = 0; c_rbeats = 0; c_rbad = 0; c_wdone = 1'b0; c_rlast = 1'b0; c_wid = '0;
        fork
            begin
                bus.AWREADY = 1'b1;
                #1;
                chk("cc_awvalid", bus.AWVALID, 1);
                tick();
                bus.AWREADY = 1'b0;
                bus.WREADY = 1'b1; wd_valid = 1'b1; wd_strb = 8'hFF;
                done = 1'b0;
                for (int i = 0; i < 20 && !done; i++) begin
                    wd_data = 64'(c_wbeats);
                    #1;
                    if (bus.WVALID && bus.WREADY) begin
                        c_wbeats++;
                        done = bus.WLAST;
                    end
                    tick();
                end
                bus.WREADY = 1'b0; wd_valid = 1'b0;
                bus.BVALID = 1'b1; bus.BID = 4'd1; bus.BRESP = 2'b00;
                for (int i = 0; i < 8 && !c_wdone; i++) begin
                    tick();
                    c_wdone = wr_done;
                end
                c_wid = wr_id;
                bus.BVALID = 1'b0;
            end
            begin
                bus.ARREADY = 1'b1;
                #1;
                chk("cc_arvalid", bus.ARVALID, 1);
                tick();
                bus.ARREADY = 1'b0;
                bus.RVALID = 1'b1; bus.RID = 4'd2; bus.RRESP = 2'b00; rd_ready = 1'b1;
                for (int i = 0; i < 20 && !c_rlast; i++) begin
                    bus.RDATA = 64'd100 + 64'(c_rbeats);
                    bus.RLAST = (c_rbeats == 3);
                    #1;
                    if (rd_valid && rd_ready) begin
                        if (rd_data !== 64'd100 + 64'(c_rbeats)) c_rbad++;
                        c_rbeats++;
                        c_rlast = rd_last;
                    end
                    tick();
                end
                bus.RVALID = 1'b0; bus.RLAST = 1'b0; rd_ready = 1'b0;
            end
        join
        chk("cc_w_beats", c_wbeats, 4);
        chk("cc_wr_done", c_wdone, 1);
        chk("cc_wr_id", c_wid, 1);
        chk("cc_r_beats", c_rbeats, 4);
        chk("cc_rd_last", c_rlast, 1);
        chk("cc_rdata", c_rbad, 0);

        // ---------------- Reset mid-write after beat 2 of 8 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000; cmd_len = 4'd7; cmd_id = 4'd4;
        tick();
        cmd_valid = 1'b0;
        bus.AWREADY = 1'b1;
        tick();
        bus.AWREADY = 1'b0;
        bus.WREADY = 1'b1; wd_valid = 1'b1;
        tick();
        tick();
        chk("mr_wvalid_before", bus.WVALID, 1);
        chk("mr_wlast_before", bus.WLAST, 0);
        ARESET = 1'b1;
        tick();
        chk("mr_awvalid", bus.AWVALID, 0);
        chk("mr_wvalid",  bus.WVALID, 0);
        chk("mr_wd_ready", wd_ready, 0);
        chk("mr_bready",  bus.BREADY, 0);
        chk("mr_arvalid", bus.ARVALID, 0);
        chk("mr_rready",  bus.RREADY, 0);
        ARESET = 1'b0;
        bus.WREADY = 1'b0; wd_valid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h7000; cmd_len = 4'd0; cmd_id = 4'd9;
        #1;
        chk("mr_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("mr_new_awvalid", bus.AWVALID, 1);
        chk("mr_new_awaddr", bus.AWADDR, 32'h7000);
        chk("mr_new_awid", bus.AWID, 9);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;

        // ---------------- Early RLAST on beat 2 of 4 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000; cmd_len = 4'd3; cmd_id = 4'd6;
        tick();
        cmd_valid = 1'b0;
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        bus.RVALID = 1'b1; bus.RLAST = 1'b0; bus.RDATA = 64'h11; rd_ready = 1'b1;
        tick();
        bus.RLAST = 1'b1; bus.RDATA = 64'h22;
        tick();
        bus.RVALID = 1'b0; bus.RLAST = 1'b0; rd_ready = 1'b0;
        chk("le_rd_err", rd_err, EXP_LEN_ERR);
        chk("le_back_to_idle", cmd_ready, 1);
        tick();
        tick();
        chk("le_rd_err_sticky", rd_err, EXP_LEN_ERR);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("le_rd_err_reset", rd_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Synthesizable AXI4 (AXI3-style signal set: WID, 4-bit LEN, 2-bit LOCK/CACHE) master.
- It is the opposite end of the AXI4_SLAVE bus: it drives AW/W/AR and RREADY/BREADY, and consumes AWREADY/WREADY/B/ARREADY/R.
- It converts a simple command port plus write/read data streams into INCR bursts of 1–16 beats.
- The write and read paths are independent state machines, so one write and one read may be outstanding at the same time.

Parameters:
- ID_W, 4, width of AWID/WID/BID/ARID/RID and cmd_id
- ADDR_W, 32, address width
- DATA_W, 64, data width; STRB_W = DATA_W/8 is derived
- SIZE_ENC, 3, AxSIZE value driven; must equal log2(DATA_W/8)

Ports:
- ACLK in 1: clock, all logic on rising edge
- ARESET in 1: synchronous active-high reset
- cmd_valid in 1: command offered
- cmd_ready out 1: command accepted when cmd_valid & cmd_ready
- cmd_write in 1: 1 = write burst, 0 = read burst
- cmd_addr in ADDR_W: burst start address
- cmd_len in 4: beats minus 1
- cmd_id in ID_W: transaction ID
- wd_valid in 1 / wd_ready out 1: write-data stream handshake
- wd_data in DATA_W / wd_strb in STRB_W: write beat payload
- rd_valid out 1 / rd_ready in 1: read-data stream handshake
- rd_data out DATA_W / rd_resp out 2 / rd_last out 1: read beat payload
- wr_done out 1: one-cycle pulse when B is accepted
- wr_resp out 2: BRESP captured with wr_done
- wr_id out ID_W: BID captured with wr_done
- rd_err out 1: sticky length-error flag (optional feature)
- AWID..AWVALID out, AWREADY in: write-address channel
- WID, WDATA, WSTRB, WLAST, WVALID out; WREADY in: write-data channel
- BID, BRESP, BVALID in; BREADY out: write-response channel
- ARID..ARVALID out, ARREADY in: read-address channel
- RID, RDATA, RRESP, RLAST, RVALID in; RREADY out: read-data channel

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - Both FSMs go to IDLE; beat counters clear.
  - All VALID/READY outputs drive 0: AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid, wd_ready.
  - wr_done=0, wr_resp=0, wr_id=0, rd_err=0; the address-channel payload registers clear to 0.
  - A burst in flight is abandoned when reset is asserted mid-burst; the slave is reset by the same signal.
- Constant outputs: AxBURST=2'b01 (INCR), AxSIZE=SIZE_ENC, AxLOCK=0, AxCACHE=0, AxPROT=0.
- cmd_ready = cmd_write ? (wstate==W_IDLE) : (rstate==R_IDLE). It is combinational and may depend on cmd_write.
- Write FSM:
  - W_IDLE: on command accept, register AWADDR/AWLEN/AWID and WID=cmd_id, then go to W_ADDR. AWVALID=1 from the next cycle.
  - W_ADDR: hold AWVALID and the payload stable until AWREADY. On the handshake, clear AWVALID, clear beat_cnt to 0, and go to W_DATA. W beats never precede the AW handshake.
  - W_DATA:
    - WVALID = wd_valid; wd_ready = WREADY; WDATA/WSTRB pass through combinationally.
    - WLAST = (beat_cnt == AWLEN).
    - Each W handshake increments beat_cnt; the handshake with WLAST goes to W_RESP.
  - W_RESP: BREADY=1. On a B handshake, pulse wr_done for 1 cycle, latch wr_resp=BRESP and wr_id=BID, then go to W_IDLE.
  - The earliest next write command is accepted in the cycle after wr_done.
- Read FSM:
  - R_IDLE: on command accept, register ARADDR/ARLEN/ARID, then go to R_ADDR with ARVALID=1.
  - R_ADDR: hold until ARREADY, then go to R_DATA with rbeat_cnt=0.
  - R_DATA:
    - RREADY = rd_ready; rd_valid = RVALID; rd_data/rd_resp/rd_last pass through from RDATA/RRESP/RLAST.
    - An R handshake with RLAST=1 goes to R_IDLE.
- Simultaneity: a write and a read command may be accepted on consecutive cycles; both channels then proceed concurrently with no ordering between them.
- Zero-latency path:
  - Command to AWVALID/ARVALID: 1 cycle.
  - AW handshake to first WVALID-eligible cycle: the next cycle.
- Counters are 4-bit and never wrap: the maximum is 15 and it equals the final beat.
- Non-OKAY BRESP/RRESP values are passed through unchanged; there is no retry.

Optional Feature:
- Macro: AXI4_BURST_MASTER_LEN_CHECK_EN.
- When defined, the read FSM counts R handshakes and sets rd_err=1 (sticky until ARESET) in either case:
  - RLAST=1 arrives with rbeat_cnt != ARLEN;
  - rbeat_cnt == ARLEN without RLAST, in which case the FSM stays in R_DATA until RLAST.
- When undefined, rd_err is tied to 0 and no read beat counter is synthesized.

Test Plan:
- Single write: cmd addr 0x1000, len 0, id 3, data 0xA5A5_0000_0000_5A5A, strb 0xFF; slave OKAY. Required: AW fields as given, one W beat with WLAST=1 and WID=3, then wr_done pulse with wr_resp=0 and wr_id=3.
- 16-beat write with WREADY toggling every other cycle: exactly 16 W handshakes, WLAST only on the 16th, and AWVALID held through a 5-cycle AWREADY stall.
- 4-beat read, addr 0x2000, id 7, with rd_ready deasserted on beat 2: RREADY follows rd_ready, 4 beats are delivered in order, rd_last on beat 4, and cmd_ready for a read returns on the next cycle.
- Concurrent: a write of len 3 and a read of len 3 accepted back to back; both complete; wr_done and rd_last both occur; neither channel stalls the other.
- Reset mid-write after beat 2 of 8: all VALID outputs are 0 the next cycle, and a new write is accepted immediately after reset drops.
- LEN_CHECK_EN: read with len 3 where the slave asserts RLAST on beat 2 → rd_err=1 and it stays 1; with the macro undefined → rd_err remains 0.
